// File: rtl/seg_display_monitor.sv
// Receive-side checker for a two-digit 7-segment counter: filters and decodes the
// segment pair, checks each accepted value is previous+1 mod 100, and times updates.
module seg_display_monitor #(
  parameter int STABLE_CYC = 4,
  parameter int PERIOD_W   = 24
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [6:0]          seg_1,
  input  logic [6:0]          seg_10,
  output logic [3:0]          digit_1,
  output logic [3:0]          digit_10,
  output logic                val_valid,
  output logic                upd,
  output logic                step_err,
  output logic                pat_err,
  output logic [PERIOD_W-1:0] period
);

  typedef enum logic {EMPTY, TRACK} state_t;

  localparam logic [13:0] BLANK     = 14'h3FFF;
  localparam logic [7:0]  SCNT_SAT  = 8'(STABLE_CYC);
  localparam logic [7:0]  SCNT_LAST = 8'(STABLE_CYC - 1);

  state_t              state, state_nxt;
  logic [13:0]         s1, s2, cand;
  logic [7:0]          scnt;
  logic [PERIOD_W-1:0] cyc_cnt, cyc_cnt_inc;
  logic [4:0]          dec_10, dec_1;
  logic [7:0]          new_val, old_val, exp_val;
  logic                stable, pair_ok, is_new, load, bad_pat;

  // Active-low pattern to {valid, digit}; blank and partial patterns are invalid.
  function automatic logic [4:0] dec7(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0000001: r = {1'b1, 4'd0};
      7'b1001111: r = {1'b1, 4'd1};
      7'b0010010: r = {1'b1, 4'd2};
      7'b0000110: r = {1'b1, 4'd3};
      7'b1001100: r = {1'b1, 4'd4};
      7'b0100100: r = {1'b1, 4'd5};
      7'b0100000: r = {1'b1, 4'd6};
      7'b0001111: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0000100: r = {1'b1, 4'd9};
      default:    r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1   <= BLANK;
      s2   <= BLANK;
      cand <= BLANK;
      scnt <= 8'd0;
    end else begin
      s1 <= {seg_10, seg_1};
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        scnt <= 8'd0;
      end else if (scnt != SCNT_SAT) begin
        scnt <= scnt + 8'd1;
      end
    end
  end

  // Saturation at SCNT_SAT makes the stable flag fire only once per run.
  assign stable = (s2 == cand) && (scnt == SCNT_LAST);

  always_comb begin
    dec_10      = dec7(cand[13:7]);
    dec_1       = dec7(cand[6:0]);
    pair_ok     = dec_10[4] & dec_1[4];
    is_new      = (dec_10[3:0] != digit_10) || (dec_1[3:0] != digit_1);
    new_val     = 8'(dec_10[3:0]) * 8'd10 + 8'(dec_1[3:0]);
    old_val     = 8'(digit_10) * 8'd10 + 8'(digit_1);
    exp_val     = (old_val == 8'd99) ? 8'd0 : old_val + 8'd1;
    cyc_cnt_inc = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 1'b1;
    bad_pat     = stable && !pair_ok;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      EMPTY: begin
        if (stable && pair_ok) begin
          load      = 1'b1;
          state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (stable && pair_ok && is_new) load = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      digit_1   <= 4'd0;
      digit_10  <= 4'd0;
      val_valid <= 1'b0;
      upd       <= 1'b0;
      step_err  <= 1'b0;
      pat_err   <= 1'b0;
      period    <= '0;
      cyc_cnt   <= '0;
    end else begin
      upd      <= load;
      step_err <= load && (state == TRACK) && (new_val != exp_val);
      if (bad_pat) pat_err <= 1'b1;
      if (load) begin
        digit_10  <= dec_10[3:0];
        digit_1   <= dec_1[3:0];
        val_valid <= 1'b1;
        cyc_cnt   <= '0;
      end else if (state == TRACK) begin
        cyc_cnt <= cyc_cnt_inc;
      end
      // Include the accepting cycle so period equals the edge distance between updates.
      if (load && state == TRACK) period <= cyc_cnt_inc;
    end
  end

endmodule

// File: tb/tb_seg_display_monitor.sv
// Bench for seg_display_monitor: three instances (default, 4-bit period, STABLE_CYC=1)
// share one stimulus and are compared each cycle against a sample-history reference model.
module tb_seg_display_monitor;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] seg_1, seg_10;

  logic [3:0]  d1_o  [3];
  logic [3:0]  d10_o [3];
  logic        vv_o  [3];
  logic        upd_o [3];
  logic        step_o[3];
  logic        pat_o [3];
  logic [23:0] per_a, per_c;
  logic [3:0]  per_b;

  always #5 CLK = ~CLK;

  seg_display_monitor #(.STABLE_CYC(4), .PERIOD_W(24)) u_a (
    .CLK(CLK), .RST(RST), .seg_1(seg_1), .seg_10(seg_10),
    .digit_1(d1_o[0]), .digit_10(d10_o[0]), .val_valid(vv_o[0]), .upd(upd_o[0]),
    .step_err(step_o[0]), .pat_err(pat_o[0]), .period(per_a));

  seg_display_monitor #(.STABLE_CYC(4), .PERIOD_W(4)) u_b (
    .CLK(CLK), .RST(RST), .seg_1(seg_1), .seg_10(seg_10),
    .digit_1(d1_o[1]), .digit_10(d10_o[1]), .val_valid(vv_o[1]), .upd(upd_o[1]),
    .step_err(step_o[1]), .pat_err(pat_o[1]), .period(per_b));

  seg_display_monitor #(.STABLE_CYC(1), .PERIOD_W(24)) u_c (
    .CLK(CLK), .RST(RST), .seg_1(seg_1), .seg_10(seg_10),
    .digit_1(d1_o[2]), .digit_10(d10_o[2]), .val_valid(vv_o[2]), .upd(upd_o[2]),
    .step_err(step_o[2]), .pat_err(pat_o[2]), .period(per_c));

  logic [6:0] enc [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  int stab   [3] = '{4, 4, 1};
  int satmax [3] = '{16777215, 15, 16777215};

  int checks = 0;
  int errors = 0;

  // Reference model: every pair sampled since reset, plus the displayed state per instance.
  logic [13:0] hist[$];
  int edge_no;
  int m_d1[3], m_d10[3], m_per[3], m_last[3];
  bit m_vv[3], m_upd[3], m_step[3], m_pat[3];

  function automatic int dec(input logic [6:0] p);
    for (int k = 0; k < 10; k++) if (enc[k] == p) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %0d expected %0d", tag, inst, obs, exp);
    end
  endtask

  // History starts with a non-blank marker then the three blank reset values
  // held by the candidate and the two sync stages.
  task automatic model_reset();
    hist.delete();
    hist.push_back(14'h0000);
    repeat (3) hist.push_back(14'h3FFF);
    edge_no = 0;
    for (int i = 0; i < 3; i++) begin
      m_d1[i] = 0; m_d10[i] = 0; m_per[i] = 0; m_last[i] = 0;
      m_vv[i] = 0; m_upd[i] = 0; m_step[i] = 0; m_pat[i] = 0;
    end
  endtask

  // A pair is accepted at the edge where the sample two edges back completes a run of
  // STABLE_CYC+1 identical samples that began after a different sample.
  task automatic model_edge();
    int top, lo, a, b, nv, ov;
    bit eq;
    logic [13:0] p;
    hist.push_back({seg_10, seg_1});
    edge_no++;
    top = hist.size() - 3;
    p = hist[top];
    for (int i = 0; i < 3; i++) begin
      m_upd[i] = 0;
      m_step[i] = 0;
      lo = top - stab[i];
      if (lo >= 1) begin
        eq = 1;
        for (int j = lo; j < top; j++) if (hist[j] != p) eq = 0;
        if (eq && hist[lo-1] != p) begin
          a = dec(p[13:7]);
          b = dec(p[6:0]);
          nv = a * 10 + b;
          ov = m_d10[i] * 10 + m_d1[i];
          if (a < 0 || b < 0) begin
            m_pat[i] = 1;
          end else if (!m_vv[i]) begin
            m_vv[i] = 1; m_upd[i] = 1; m_d10[i] = a; m_d1[i] = b; m_last[i] = edge_no;
          end else if (nv != ov) begin
            m_upd[i] = 1;
            m_step[i] = (nv != (ov + 1) % 100);
            m_per[i] = (edge_no - m_last[i] > satmax[i]) ? satmax[i] : edge_no - m_last[i];
            m_last[i] = edge_no;
            m_d10[i] = a; m_d1[i] = b;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] get_per(input int i);
    case (i)
      0:       return {8'd0, per_a};
      1:       return {28'd0, per_b};
      default: return {8'd0, per_c};
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("digit_1",   i, {28'd0, d1_o[i]},  m_d1[i]);
      chk("digit_10",  i, {28'd0, d10_o[i]}, m_d10[i]);
      chk("val_valid", i, {31'd0, vv_o[i]},  {31'd0, m_vv[i]});
      chk("upd",       i, {31'd0, upd_o[i]}, {31'd0, m_upd[i]});
      chk("step_err",  i, {31'd0, step_o[i]}, {31'd0, m_step[i]});
      chk("pat_err",   i, {31'd0, pat_o[i]}, {31'd0, m_pat[i]});
      chk("period",    i, get_per(i), m_per[i]);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic hold_raw(input logic [6:0] p10, input logic [6:0] p1, input int n);
    seg_10 = p10;
    seg_1  = p1;
    repeat (n) tick();
  endtask

  task automatic hold(input int t, input int o, input int n);
    hold_raw(enc[t], enc[o], n);
  endtask

  initial begin
    int lastv, v, r, n;
    seg_10 = enc[0];
    seg_1  = enc[0];
    #1 RST = 1'b0;
    model_reset();
    #1 check_all();
    #4998 RST = 1'b1;

    // Count 00 -> 01 -> 02
    hold(0, 0, 10);
    hold(0, 1, 50);
    hold(0, 2, 50);
    chk("step1_d10", 0, {28'd0, d10_o[0]}, 0);
    chk("step1_d1",  0, {28'd0, d1_o[0]}, 2);
    chk("step1_per", 0, {8'd0, per_a}, 50);

    // Wrap 98 -> 99 -> 00
    hold(9, 8, 20);
    hold(9, 9, 20);
    hold(0, 0, 20);
    chk("wrap_d10", 0, {28'd0, d10_o[0]}, 0);
    chk("wrap_d1",  0, {28'd0, d1_o[0]}, 0);

    // Skip 05 -> 07, then a two-sample glitch to 08
    hold(0, 5, 20);
    hold(0, 7, 20);
    hold(0, 8, 2);
    hold(0, 7, 20);
    chk("glitch_d1", 0, {28'd0, d1_o[0]}, 7);

    // Blank ones digit, then recover to 08
    hold_raw(enc[0], 7'h7F, 10);
    chk("blank_pat", 0, {31'd0, pat_o[0]}, 1);
    hold(0, 8, 20);
    chk("recover_pat", 0, {31'd0, pat_o[0]}, 1);
    chk("recover_d1",  0, {28'd0, d1_o[0]}, 8);

    // Reset mid-run at 42, restart at 17
    hold(4, 2, 20);
    RST = 1'b0;
    seg_10 = enc[1];
    seg_1  = enc[7];
    model_reset();
    #1 check_all();
    chk("rst_vv",  0, {31'd0, vv_o[0]}, 0);
    chk("rst_pat", 0, {31'd0, pat_o[0]}, 0);
    #19999 RST = 1'b1;
    hold(1, 7, 20);
    chk("restart_vv",  0, {31'd0, vv_o[0]}, 1);
    chk("restart_per", 0, {8'd0, per_a}, 0);

    // Updates 300 cycles apart saturate the 4-bit period
    hold(1, 8, 300);
    hold(1, 9, 300);
    chk("sat_per4",  1, {28'd0, per_b}, 15);
    chk("sat_per24", 0, {8'd0, per_a}, 300);

    // Random mix of increments, jumps, invalid patterns and short holds
    lastv = 19;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      n = $urandom_range(1, 12);
      if (r < 6) begin
        v = (lastv + 1) % 100;
        hold(v / 10, v % 10, n);
        lastv = v;
      end else if (r < 8) begin
        v = $urandom_range(0, 99);
        hold(v / 10, v % 10, n);
        lastv = v;
      end else begin
        hold_raw(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), n);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_monitor.md
Name: seg_display_monitor

Overview:
- Receive-side checker for the two-digit 7-segment counter display: samples `seg_10`/`seg_1`, filters glitches and decodes the patterns back to BCD digits.
- Verifies that each new value is the previous value +1 (mod 100) and measures clock cycles between display updates.
- Used in benches and on-board self-test next to the display counter, fed from its segment outputs.

Parameters:
- `STABLE_CYC`, 4: consecutive identical samples required before a pattern pair is accepted (legal range 1..255).
- `PERIOD_W`, 24: width of the update-period counter.

Ports:
- `CLK` input 1: system clock, rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `seg_1` input 7: ones-digit segments, active-low, bit6=a … bit0=g.
- `seg_10` input 7: tens-digit segments, same encoding.
- `digit_1` output 4: decoded accepted ones digit (BCD).
- `digit_10` output 4: decoded accepted tens digit (BCD).
- `val_valid` output 1: at least one valid pair has been accepted since reset.
- `upd` output 1: one-cycle pulse when a new valid pair is accepted.
- `step_err` output 1: one-cycle pulse, coincident with `upd`, when the new value ≠ previous+1 mod 100.
- `pat_err` output 1: sticky; an accepted pair contained a non-digit pattern.
- `period` output `PERIOD_W`: cycles between the last two accepted updates, saturating.

Behaviour:
- **Reset** (`RST`=0, async): all registers cleared. `digit_1`=`digit_10`=0; `val_valid`=`upd`=`step_err`=`pat_err`=0; `period`=0; FSM=EMPTY; sync regs and candidate = 7'h7F pair (blank).
- **Input sync**: 2-flop register on the 14-bit pair; the second stage is `s2`.
- **Stability filter**: candidate register `cand` plus 8-bit `scnt`.
  - `s2`≠`cand`: `cand`<=`s2`, `scnt`<=0.
  - Otherwise `scnt` increments, saturating at `STABLE_CYC`.
  - The pair is "stable" in the cycle `scnt` first reaches `STABLE_CYC`-1 with `s2`==`cand`.
- **Latency**: the pair is acceptable at edge k+`STABLE_CYC`+2 after a pair change presented before edge k. The `upd` pulse is registered and visible in the following cycle.
- **Decode** (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other pattern, including blank 1111111, is invalid.
- **Stable pair with either digit invalid**: `pat_err`<=1 (sticky until reset). No `upd`; digits, `period` and FSM unchanged.
- **Stable valid pair equal to current accepted value**: ignored (no pulse).
- **FSM EMPTY**: first stable valid pair → load digits, `val_valid`<=1, `upd` pulse, no step check, cycle counter <=0, go to TRACK. `period` stays 0.
- **FSM TRACK**: stable valid pair different from current →
  - load digits and pulse `upd`;
  - compute new = 10·`digit_10`+`digit_1` against old.
  - Expected next: old=99 → new=0; otherwise old+1. `step_err`=1 on mismatch.
  - `period`<=cycle counter value; cycle counter <=0.
- **Cycle counter**: runs only in TRACK, +1 per clock, saturates at 2^`PERIOD_W`-1. `period` holds its last value between updates.
- **Stability boundary**: a pattern held fewer than `STABLE_CYC` samples is never accepted, and glitches restart `scnt`. `STABLE_CYC`=1 accepts in the first sample where `s2`==`cand`.
- **Simultaneous events**: an invalid-pattern acceptance never coincides with `upd`; at most one accept per cycle.
- **Reset mid-operation**: immediate return to EMPTY; the next valid pair is treated as the first (no `step_err` from the pre-reset value).

Test Plan:
- **Step 1 to 02**: `RST`=0 5000 ns, then release; drive `seg_10`=0000001, `seg_1`=0000001 (00) for 10 clocks, then 01, 02 each 50 clocks → three `upd` pulses. Digits end 0/2, `step_err` never, `period`=50 after 02.
- **Wrap**: drive 98, 99, 00 each 20 clocks → `upd`×3, `step_err`=0 on 99→00, `digit_10`=0, `digit_1`=0.
- **Skip and glitch**: from 05 drive 07 → `step_err` pulse with `upd`, digits 0/7. Then a 2-cycle 08 glitch with `STABLE_CYC`=4 → no `upd`, digits stay 0/7.
- **Invalid pattern**: `seg_1`=1111111 held 10 clocks → `pat_err`=1 stays high, no `upd`. Then 08 → `upd`, no `step_err`, `pat_err` still 1.
- **Reset mid-run**: at value 42, pulse `RST` low 20000 ns → all outputs 0. First pair 17 → `upd`, `val_valid`=1, `step_err`=0, `period`=0.
- **Period saturation**: `PERIOD_W`=4, updates 300 clocks apart → `period`=15.
